// File: rtl/obs_pkg.sv
// obs_pkg: shared types, default operand width and product-width helpers for the OBS carry-less multiplier
package obs_pkg;
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    localparam int OBS_N = 12;
    function automatic int half_w(input int n);
        return n / 2;
    endfunction
    function automatic int prod_w(input int n);
        return 2 * n - 1;
    endfunction
endpackage

// File: rtl/clmul_half.sv
// clmul_half: purely combinational H x H carry-less (GF(2)[x]) multiplier, 2H-1 bit product
module clmul_half #(
    parameter int H = 6
) (
    input  logic [H-1:0]   x,
    input  logic [H-1:0]   y,
    output logic [2*H-2:0] p
);
    always_comb begin
        p = '0;
        for (int i = 0; i < H; i++) p = y[i] ? p ^ ({{(H-1){1'b0}}, x} << i) : p;
    end
endmodule

// File: rtl/obs_mult_sequencer.sv
// obs_mult_sequencer: time-multiplexed carry-less multiplier; four half-products on one shared
// H x H core over four cycles, XOR-accumulated into the overlapped 2N-1 bit product
module obs_mult_sequencer
    import obs_pkg::*;
#(
    parameter int N = OBS_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-2:0] result
);
    localparam int H  = half_w(N);
    localparam int PW = prod_w(N);

    if (N % 2 != 0 || N < 4) begin : g_bad_n
        $error("obs_mult_sequencer: N must be even and >= 4");
    end

    state_t         state, state_nx;
    logic [1:0]     idx;
    logic [N-1:0]   a_q, b_q;
    logic [PW-1:0]  acc, ext, term;
    logic [H-1:0]   op_x, op_y;
    logic [2*H-2:0] hp;
    logic           accept;

    assign accept = in_valid && in_ready;
    // idx[1] picks the high half of a, idx[0] the high half of b: aL*bL, aL*bH, aH*bL, aH*bH
    assign op_x   = idx[1] ? a_q[N-1:H] : a_q[H-1:0];
    assign op_y   = idx[0] ? b_q[N-1:H] : b_q[H-1:0];
    assign ext    = {{N{1'b0}}, hp};
    assign term   = idx == 2'd0 ? ext : idx == 2'd3 ? ext << (2 * H) : ext << H;
    assign result = acc;

    clmul_half #(.H(H)) u_core (
        .x(op_x),
        .y(op_y),
        .p(hp)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE && in_valid      ? MUL  :
                   state == MUL  && idx == 2'd3   ? DONE :
                   state == DONE && out_ready     ? IDLE : state;
    end

    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
            acc <= '0;
            a_q <= '0;
            b_q <= '0;
        end else if (accept) begin
            idx <= '0;
            acc <= '0;
            a_q <= a;
            b_q <= b;
        end else if (state == MUL) begin
            idx <= idx + 2'd1;
            acc <= acc ^ term;
        end
    end
endmodule
